ps2_bar_keys: RTL and testbench

PS/2 keyboard front end that produces the `l_bar_buttons` and `r_bar_buttons` vectors consumed by the pong game top level, so the paddles can be driven from a keyboard instead of board push-buttons. It receives device-to-host PS/2 frames, decodes make, break and extended (E0) scancodes, and holds a level per mapped key. It sits between the board PS/2 pins and the game top level, in the same clock domain as the rest of the design.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_rx.sv | 132 +++++++++++++
 rtl/ps2_bar_keys.sv | 75 +++++++
 tb/tb_ps2_bar_keys.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end: receiver states,
// scancodes of the mapped keys and the button bit positions in the paddle vectors.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // Prefix and break codes
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;

    // Left paddle: W S A D (set 2, non-extended)
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_D = 8'h23;

    // Right paddle: arrow keys, low byte after an E0 prefix
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, clock glitch filter,
// frame FSM and, when PS2_TIMEOUT_EN is defined, a mid-frame stall timeout.
//
// state  | meaning
// IDLE   | waiting for the start bit edge
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd parity bit
// STOP   | checking stop bit and parity, then back to IDLE
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    logic [1:0]            clk_sync;
    logic [1:0]            data_sync;
    logic [FILTER_LEN-1:0] filt;
    logic                  clk_filt;
    logic                  fall;
    logic                  data_s;
    logic                  tmo_fire;

    rx_state_t  state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       par_bit;

    // The bus idles high, so synchronizers and filter come out of reset high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt      <= '1;
            clk_filt  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            filt      <= {filt[FILTER_LEN-2:0], clk_sync[1]};
            if (&filt)
                clk_filt <= 1'b1;
            else if (~|filt)
                clk_filt <= 1'b0;
        end
    end

    assign fall   = clk_filt & ~|filt;
    assign data_s = data_sync[1];

`ifdef PS2_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Down-counter reloaded on every edge and in IDLE; terminal count aborts the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_cnt <= '0;
        else if (state == IDLE || fall)
            tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
        else if (tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - 1'b1;
    end

    assign tmo_fire = (state != IDLE) && (tmo_cnt == '0);
`else
    logic unused_tmo;

    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign tmo_fire   = 1'b0;
`endif

    // A filtered edge takes priority over a timeout expiring in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_s;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if ((^{shreg, par_bit}) && data_s) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (tmo_fire) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_bar_keys.sv
// PS/2 keyboard to paddle buttons: decodes make/break/E0 scancodes into held-key levels.
// Build option: PS2_TIMEOUT_EN enables the receiver's stalled-frame timeout.
module ps2_bar_keys
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] l_bar_buttons,
    output logic [3:0] r_bar_buttons,
    output logic       frame_err
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       ext_pend;
    logic       brk_pend;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    // A dropped frame may have carried a prefix, so the pending flags are discarded with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_pend      <= 1'b0;
            brk_pend      <= 1'b0;
            l_bar_buttons <= '0;
            r_bar_buttons <= '0;
        end else if (byte_valid) begin
            if (byte_data == SC_E0) begin
                ext_pend <= 1'b1;
            end else if (byte_data == SC_F0) begin
                brk_pend <= 1'b1;
            end else begin
                if (!ext_pend) begin
                    case (byte_data)
                        SC_W:    l_bar_buttons[BTN_UP]    <= ~brk_pend;
                        SC_S:    l_bar_buttons[BTN_DOWN]  <= ~brk_pend;
                        SC_A:    l_bar_buttons[BTN_LEFT]  <= ~brk_pend;
                        SC_D:    l_bar_buttons[BTN_RIGHT] <= ~brk_pend;
                        default: ;
                    endcase
                end else begin
                    case (byte_data)
                        SC_UP:    r_bar_buttons[BTN_UP]    <= ~brk_pend;
                        SC_DOWN:  r_bar_buttons[BTN_DOWN]  <= ~brk_pend;
                        SC_LEFT:  r_bar_buttons[BTN_LEFT]  <= ~brk_pend;
                        SC_RIGHT: r_bar_buttons[BTN_RIGHT] <= ~brk_pend;
                        default:  ;
                    endcase
                end
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
            end
        end else if (frame_err) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_bar_keys.sv
// Scoreboard bench for ps2_bar_keys: frames are driven on the pins, expected events
// are queued, and a monitor compares each accepted byte or frame error as it appears.
module tb_ps2_bar_keys;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 20000;
    localparam int HALF           = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] l_bar_buttons;
    logic [3:0] r_bar_buttons;
    logic       frame_err;

    ps2_bar_keys #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .l_bar_buttons (l_bar_buttons),
        .r_bar_buttons (r_bar_buttons),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [7:0] code;
        logic [3:0] l;
        logic [3:0] r;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic pend_btn = 1'b0;
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: buttons are registered one cycle after byte_valid.
    always @(negedge clk) begin
        if (pend_btn) begin
            check("l_bar_buttons", {28'd0, l_bar_buttons}, {28'd0, cur.l});
            check("r_bar_buttons", {28'd0, r_bar_buttons}, {28'd0, cur.r});
            pend_btn = 1'b0;
        end
        if (!reset && (dut.byte_valid || frame_err)) begin
            check("valid_err_exclusive", {31'd0, dut.byte_valid & frame_err}, 32'd0);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_event: byte_valid=%0b frame_err=%0b, none required (t=%0t)",
                         dut.byte_valid, frame_err, $time);
            end else begin
                cur = exp_q.pop_front();
                check("event_kind_err", {31'd0, frame_err}, {31'd0, cur.is_err});
                if (dut.byte_valid) begin
                    check("byte_data", {24'd0, dut.byte_data}, {24'd0, cur.code});
                    pend_btn = 1'b1;
                end else begin
                    check("l_hold_on_err", {28'd0, l_bar_buttons}, {28'd0, cur.l});
                    check("r_hold_on_err", {28'd0, r_bar_buttons}, {28'd0, cur.r});
                end
            end
        end
    end

    // Bits go out start first; stop/parity corruption and truncation are selectable.
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HALF) @(negedge clk);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [3:0] el, input logic [3:0] er);
        exp_q.push_back('{is_err: 1'b0, code: b, l: el, r: er});
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    task automatic push_err(input logic [3:0] el, input logic [3:0] er);
        exp_q.push_back('{is_err: 1'b1, code: 8'h00, l: el, r: er});
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || pend_btn) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0 || pend_btn) begin
            n_fails++;
            $display("FAIL drain_%s: %0d events still outstanding, 0 required", tag, exp_q.size());
        end
    endtask

    initial begin
        repeat (5) @(negedge clk);
        check("reset_l", {28'd0, l_bar_buttons}, 32'd0);
        check("reset_r", {28'd0, r_bar_buttons}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // Make / break of W
        send_byte(8'h1D, 4'b0001, 4'b0000);
        send_byte(8'hF0, 4'b0001, 4'b0000);
        send_byte(8'h1D, 4'b0000, 4'b0000);
        drain("make_break");

        // Right arrow while W is held
        send_byte(8'h1D, 4'b0001, 4'b0000);
        send_byte(8'hE0, 4'b0001, 4'b0000);
        send_byte(8'h74, 4'b0001, 4'b1000);
        send_byte(8'hE0, 4'b0001, 4'b1000);
        send_byte(8'hF0, 4'b0001, 4'b1000);
        send_byte(8'h74, 4'b0001, 4'b0000);
        send_byte(8'hF0, 4'b0001, 4'b0000);
        send_byte(8'h1D, 4'b0000, 4'b0000);
        drain("extended");

        // Parity error, then a good S
        push_err(4'b0000, 4'b0000);
        send_frame(8'h1B, 1'b1, 1'b0, 11);
        send_byte(8'h1B, 4'b0010, 4'b0000);
        send_byte(8'hF0, 4'b0010, 4'b0000);
        send_byte(8'h1B, 4'b0000, 4'b0000);
        drain("parity");

        // Short glitch on the clock line must not be seen as an edge
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (60) @(negedge clk);
        check("glitch_l", {28'd0, l_bar_buttons}, 32'd0);
        check("glitch_r", {28'd0, r_bar_buttons}, 32'd0);
        send_byte(8'h1C, 4'b0100, 4'b0000);
        send_byte(8'hF0, 4'b0100, 4'b0000);
        send_byte(8'h1C, 4'b0000, 4'b0000);
        drain("glitch");

        // Stop error drops a pending E0, so a following 75 is keypad 8 and ignored
        send_byte(8'hE0, 4'b0000, 4'b0000);
        push_err(4'b0000, 4'b0000);
        send_frame(8'h11, 1'b0, 1'b1, 11);
        send_byte(8'h75, 4'b0000, 4'b0000);
        send_byte(8'hE0, 4'b0000, 4'b0000);
        send_byte(8'h6B, 4'b0000, 4'b0100);
        send_byte(8'hE0, 4'b0000, 4'b0100);
        send_byte(8'hF0, 4'b0000, 4'b0100);
        send_byte(8'h6B, 4'b0000, 4'b0000);
        drain("stop_err");

`ifdef PS2_TIMEOUT_EN
        push_err(4'b0000, 4'b0000);
        send_frame(8'h23, 1'b0, 1'b0, 5);
        repeat (TIMEOUT_CYCLES + 200) @(negedge clk);
        drain("timeout");
        send_byte(8'h23, 4'b1000, 4'b0000);
        send_byte(8'hF0, 4'b1000, 4'b0000);
        send_byte(8'h23, 4'b0000, 4'b0000);
        drain("after_timeout");
`endif

        // Async reset in the middle of a frame after E0 75
        send_byte(8'hE0, 4'b0000, 4'b0000);
        send_byte(8'h75, 4'b0000, 4'b0001);
        send_byte(8'h1C, 4'b0100, 4'b0001);
        drain("pre_reset");
        send_frame(8'hE0, 1'b0, 1'b0, 3);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_l", {28'd0, l_bar_buttons}, 32'd0);
        check("async_reset_r", {28'd0, r_bar_buttons}, 32'd0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        send_byte(8'h75, 4'b0000, 4'b0000);
        drain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
